// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide controller.
// Both MULT and DIV take ITER_COUNT single-bit steps.
package mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [5:0] CNT_LAST = 6'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a two's-complement value; the most negative value maps to 2**(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between a requester and mult_div_ctrl.
// The requester drives start/op/operands; the controller drives status and HI/LO.
interface mult_div_ctrl_if;
    import mult_div_pkg::*;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );

endinterface

// File: rtl/mult_div_ctrl_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, emit a quotient bit.
// Purely combinational, zero latency; no flow control.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] quo_nxt
);

    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, divisor};
        // diff[W] set means the trial subtraction borrowed: restore.
        if (!diff[W]) begin
            rem_nxt = diff[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and restoring divider with HI/LO result registers.
// Latency: done 32 cycles after the accept edge (1 cycle for divide-by-zero); starts while busy are dropped.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_ctrl_if.slave  bus
);

    state_t           state;
    logic [5:0]       cnt;
    logic [WIDTH:0]   acc;      // Booth accumulator (one guard bit) or division remainder
    logic [WIDTH-1:0] qr;       // Booth multiplier/low product or dividend/quotient shifter
    logic [WIDTH-1:0] m;        // multiplicand or divisor magnitude
    logic             qm1;
    logic             neg_q;
    logic             neg_r;
    logic             busy_r, done_r, dz_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    logic [WIDTH:0]   m_ext, booth_sum, booth_acc_nxt;
    logic [WIDTH-1:0] booth_q_nxt;
    logic [WIDTH-1:0] rem_nxt, quo_nxt, rem_fix, quo_fix;

    always_comb begin
        m_ext = {m[WIDTH-1], m};
        case ({qr[0], qm1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        booth_acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q_nxt   = {booth_sum[0], qr[WIDTH-1:1]};
    end

    div_step #(.W(WIDTH)) u_div_step (
        .rem     (acc[WIDTH-1:0]),
        .quo     (qr),
        .divisor (m),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    assign quo_fix = neg_q ? -quo_nxt : quo_nxt;
    assign rem_fix = neg_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            qr     <= '0;
            m      <= '0;
            qm1    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        qm1    <= 1'b0;
                        busy_r <= 1'b1;
                        if (bus.op == OP_DIV) begin
                            state <= DIV;
                            qr    <= mag(bus.a_in);
                            m     <= mag(bus.b_in);
                            neg_q <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                            neg_r <= bus.a_in[WIDTH-1];
                        end else begin
                            state <= MULT;
                            qr    <= bus.b_in;
                            m     <= bus.a_in;
                        end
                    end
                end
                MULT: begin
                    acc <= booth_acc_nxt;
                    qr  <= booth_q_nxt;
                    qm1 <= qr[0];
                    cnt <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        hi_r   <= booth_acc_nxt[WIDTH-1:0];
                        lo_r   <= booth_q_nxt;
                    end
                end
                DIV: begin
                    if (m == '0) begin
                        // Divide by zero: finish immediately, result registers untouched.
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        dz_r   <= 1'b1;
                    end else begin
                        acc <= {1'b0, rem_nxt};
                        qr  <= quo_nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == CNT_LAST) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            hi_r   <= rem_fix;
                            lo_r   <= quo_fix;
                        end
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.hi_out   = hi_r;
    assign bus.lo_out   = lo_r;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed, table-driven bench for mult_div_ctrl plus hand-written divide-by-zero,
// start-while-busy and mid-operation reset sequences.
module tb_mult_div_ctrl;
    import mult_div_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mult_div_ctrl_if bus ();

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation; operands are scrambled right after the accept edge.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc, output logic [31:0] hi,
                         output logic [31:0] lo, output logic dz, output logic timeout);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a_in  = ~a;
        bus.b_in  = b ^ 32'h5A5A_0001;
        lat = 0; busy_cyc = 0; hi = '0; lo = '0; dz = 1'b0; timeout = 1'b1;
        if (bus.busy) busy_cyc++;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.done) begin
                hi = bus.hi_out; lo = bus.lo_out; dz = bus.div_zero; timeout = 1'b0;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
    endtask

    int          lat, bcyc, ndone;
    logic [31:0] hi, lo;
    logic        dz, to;

    initial begin
        vecs[0] = '{OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[4] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_MULT, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{OP_DIV,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7] = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
        vecs[8] = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[9] = '{OP_MULT, 32'h5555_5556, 32'h3333_3333, 32'h1111_1111, 32'h2222_2222};

        bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
        #12;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_dz",   64'(bus.div_zero), 64'd0);
        chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcyc, hi, lo, dz, to);
            chk($sformatf("v%0d_timeout", i), 64'(to), 64'd0);
            chk($sformatf("v%0d_result", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd32);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'd32);
            chk($sformatf("v%0d_div_zero", i), 64'(dz), 64'd0);
            @(posedge clock); #1;
            chk($sformatf("v%0d_done_one_cycle", i), 64'(bus.done), 64'd0);
        end

        // Divide by zero after a result of 0x11111111/0x22222222.
        do_op(OP_DIV, 32'd5, 32'd0, lat, bcyc, hi, lo, dz, to);
        chk("dz_timeout", 64'(to), 64'd0);
        chk("dz_latency", 64'(lat), 64'd1);
        chk("dz_flag", 64'(dz), 64'd1);
        chk("dz_hilo_held", {hi, lo}, 64'h1111_1111_2222_2222);
        @(posedge clock); #1;
        chk("dz_pulse_one_cycle", 64'(bus.done) + 64'(bus.div_zero), 64'd0);

        // Start pulse while busy must be dropped.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_DIV; bus.a_in = 32'h8000_0000; bus.b_in = 32'hFFFF_FFFF;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a_in = 32'd3; bus.b_in = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        ndone = 0; hi = '0; lo = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.done) begin ndone++; hi = bus.hi_out; lo = bus.lo_out; end
        end
        chk("busy_start_done_count", 64'(ndone), 64'd1);
        chk("busy_start_result", {hi, lo}, 64'h0000_0000_8000_0000);

        // Reset asserted during iteration 10 of a MULT.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a_in = 32'd1234; bus.b_in = 32'd5678;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        do_op(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, lat, bcyc, hi, lo, dz, to);
        chk("postrst_timeout", 64'(to), 64'd0);
        chk("postrst_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("postrst_latency", 64'(lat), 64'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clock  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  in  1  operation select: 0 = MULT, 1 = DIV.
REQ-006 Port: a_in  in  32  multiplicand or dividend, two's complement.
REQ-007 Port: b_in  in  32  multiplier or divisor, two's complement.
REQ-008 Port: busy  out  1  high while iterating (MULT or DIV state).
REQ-009 Port: done  out  1  one-cycle completion pulse.
REQ-010 Port: div_zero  out  1  one-cycle pulse, coincident with done, on divide by zero.
REQ-011 Port: hi_out  out  32  HI register: product[63:32] or remainder.
REQ-012 Port: lo_out  out  32  LO register: product[31:0] or quotient.

Function
REQ-013 FSM states SHALL be IDLE, MULT, DIV and DONE.
REQ-014 At edge E0, if the FSM is in IDLE and start=1, the block SHALL latch a_in, b_in and op, clear the iteration counter, and enter MULT or DIV according to op.
REQ-015 When start=1 in MULT, DIV or DONE, the block SHALL ignore it with no queuing.
REQ-016 The MULT state SHALL perform radix-2 signed Booth multiplication, one step per cycle, for 32 steps (edges E1..E32).
REQ-017 The DIV state SHALL perform restoring division on operand magnitudes, one step per cycle, for 32 steps (edges E1..E32), followed by sign correction.
REQ-018 At edge E32 the block SHALL load hi_out/lo_out and enter DONE; done=1 for exactly the cycle E32..E33, then the FSM returns to IDLE at E33.
REQ-019 busy SHALL be 1 from E0 until E32, and 0 in IDLE and DONE.
REQ-020 MULT SHALL produce {hi_out, lo_out} equal to the full signed 64-bit product.
REQ-021 DIV SHALL truncate the quotient toward zero; lo_out = quotient and hi_out = remainder, with the remainder's sign equal to the dividend's sign.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo_out = 0x80000000 and hi_out = 0 (wrap, no flag).
REQ-023 DIV with latched b = 0 SHALL skip iteration: DONE at E1, done=1 and div_zero=1 for one cycle, hi_out/lo_out unchanged.
REQ-024 hi_out/lo_out SHALL hold their value except at a DONE entry caused by a valid operation.
REQ-025 Changes on a_in, b_in or op after E0 SHALL not affect the result.
REQ-026 Outputs SHALL be driven from registers only (no combinational path from inputs).

Reset
REQ-027 When reset=0, the block SHALL immediately force: FSM = IDLE, counter = 0, busy = 0, done = 0, div_zero = 0, hi_out = 0, lo_out = 0, internal operands = 0.
REQ-028 When reset is asserted mid-operation, the operation SHALL be abandoned with no done pulse and no result written.
REQ-029 The first start is accepted at the first rising edge with reset=1.

Structure
REQ-030 Package mult_div_pkg SHALL hold: the state enum, the op encodings (OP_MULT = 0, OP_DIV = 1), WIDTH, and ITER_COUNT = 32.
REQ-031 One combinational sub-module, div_step, SHALL implement one restoring-division step (shift, trial subtract, quotient bit); the Booth step is inline.
REQ-032 The iteration counter SHALL be 6 bits, with terminal value 31 triggering the DONE transition.

Verification
REQ-033 MULT 7 × 0xFFFFFFFD (-3) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; done exactly 32 edges after the accept edge; busy high for 32 cycles.
REQ-034 MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> lo = 0xFFFFFFFD, hi = 0x00000001.
REQ-036 DIV 5 / 0 with prior hi/lo = 0x11111111/0x22222222 -> done and div_zero high one cycle after the accept edge; hi/lo unchanged.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0; a start pulse during busy is ignored (exactly one done pulse).
REQ-038 reset=0 asserted at iteration 10 of a MULT -> busy, done, hi and lo all go to 0 immediately; no done pulse; the next start completes normally.
